// File: rtl/prbs10_pkg.sv
// Shared definitions for the PRBS10 (x^10+x^7+1) checker: taps, period, state encoding, next-word function.
package prbs10_pkg;

    localparam int TAP_HI        = 9;
    localparam int TAP_LO        = 6;
    localparam int PRBS10_PERIOD = 1023;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    function automatic logic [9:0] nxt(input logic [9:0] d);
        return {d[8:0], d[TAP_HI] ^ d[TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs10_period_meas.sv
// Measures the PRBS10 period in valid samples between consecutive 10'd1 markers while locked.
// Latency: period_o / period_vld_o update one cycle after the closing marker sample.
module prbs10_period_meas
    import prbs10_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        locked,
    input  logic        en,
    input  logic [9:0]  data,
    output logic [10:0] period_o,
    output logic        period_vld_o
);

    // Wide enough to hold twice the nominal period before saturating.
    localparam int PW = $clog2(PRBS10_PERIOD + 1) + 1;

    logic [PW-1:0] cnt_q;
    logic          seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            period_o     <= '0;
            period_vld_o <= 1'b0;
        end else begin
            period_vld_o <= 1'b0;
            if (!locked) begin
                cnt_q  <= '0;
                seen_q <= 1'b0;
            end else if (en) begin
                if (data == 10'd1) begin
                    // Count includes the marker itself, so markers 1023 samples apart read 1023.
                    if (seen_q) begin
                        period_o     <= cnt_q;
                        period_vld_o <= 1'b1;
                    end
                    seen_q <= 1'b1;
                    cnt_q  <= PW'(1);
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prbs10_chk.sv
// PRBS10 checker: self-syncs in SEARCH, flywheels in LOCKED, counts mismatches; period measurement under PRBS10_PERIOD_EN.
// Latency: locked_o / err_o / err_cnt_o reflect an en_i sample one cycle later.
module prbs10_chk
    import prbs10_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [9:0]       data_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [10:0]      period_o,
    output logic             period_vld_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    chk_state_t       state_q, state_d;
    logic [9:0]       pred_q, pred_d;
    logic [MW-1:0]    match_q, match_d;
    logic [UW-1:0]    miss_q, miss_d;
    logic             err_d;
    logic             err_inc;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            pred_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_o   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        err_inc = 1'b0;
        if (en_i) begin
            case (state_q)
                SEARCH: begin
                    // Always re-seed from the input so we sync to whatever phase arrives.
                    pred_d = nxt(data_i);
                    if ((data_i == pred_q) && (data_i != '0)) begin
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = nxt(pred_q);
                    if (data_i == pred_q) begin
                        miss_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        if (miss_q == UW'(UNLOCK_CNT - 1)) begin
                            state_d = SEARCH;
                            match_d = '0;
                            miss_d  = '0;
                            pred_d  = nxt(data_i);
                        end else begin
                            miss_d = miss_q + UW'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_cnt_o = err_cnt_q;

`ifdef PRBS10_PERIOD_EN
    prbs10_period_meas u_period_meas (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked_o),
        .en           (en_i),
        .data         (data_i),
        .period_o     (period_o),
        .period_vld_o (period_vld_o)
    );
`else
    assign period_o     = '0;
    assign period_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_prbs10_chk.sv
// Randomized scoreboard bench for prbs10_chk against a table-driven sequence model.
module tb_prbs10_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [9:0]  data_i = '0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [10:0] period_o;
    logic        period_vld_o;

    always #5 clk = ~clk;

    prbs10_chk dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .data_i       (data_i),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .period_o     (period_o),
        .period_vld_o (period_vld_o)
    );

    typedef struct {
        bit locked;
        bit err;
        int cnt;
        bit pvld;
        int period;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // The 1023-word sequence and each word's position in it.
    logic [9:0] seq[0:1022];
    int         pos[0:1023];

    // Model state, expressed as sequence positions and plain counts.
    bit         m_locked;
    logic [9:0] m_pred;
    int         m_hits, m_miss, m_cnt;
    bit         m_seen;
    int         m_idx, m_last, m_period;
    logic [9:0] g;

    function automatic logic [9:0] succ(input logic [9:0] x);
        if (x == 10'd0) return 10'd0;
        return seq[(pos[x] + 1) % 1023];
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pred = '0; m_hits = 0; m_miss = 0; m_cnt = 0;
        m_seen = 0; m_idx = 0; m_last = 0; m_period = 0;
    endtask

    task automatic push_exp(input bit err, input bit pvld);
        exp_t e;
        e.locked = m_locked;
        e.err    = err;
        e.cnt    = m_cnt;
`ifdef PRBS10_PERIOD_EN
        e.pvld   = pvld;
        e.period = m_period;
`else
        e.pvld   = 1'b0;
        e.period = 0;
        if (pvld) e.pvld = 1'b0;
`endif
        q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            en_i = 1'b0;
            #1;
            chk("rst_locked", locked_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_err_cnt", err_cnt_o, 0);
            chk("rst_period", period_o, 0);
            chk("rst_period_vld", period_vld_o, 0);
            model_reset();
            push_exp(1'b0, 1'b0);
        end
    endtask

    task automatic drive(input bit en, input logic [9:0] d);
        bit was, err, pvld;
        @(negedge clk);
        rst = 1'b0;
        en_i = en;
        data_i = d;
        was = m_locked;
        err = 0;
        pvld = 0;
        if (!was) m_seen = 0;
        if (en) begin
            if (was) begin
                m_idx++;
                if (d == 10'd1) begin
                    if (m_seen) begin
                        m_period = (m_idx - m_last > 2047) ? 2047 : m_idx - m_last;
                        pvld = 1;
                    end
                    m_seen = 1;
                    m_last = m_idx;
                end
                if (d == m_pred) begin
                    m_miss = 0;
                    m_pred = succ(m_pred);
                end else begin
                    err = 1;
                    if (m_cnt < 65535) m_cnt++;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_locked = 0; m_hits = 0; m_miss = 0;
                        m_pred = succ(d);
                    end else begin
                        m_pred = succ(m_pred);
                    end
                end
            end else begin
                if (d != 10'd0 && d == m_pred) m_hits++;
                else m_hits = 0;
                m_pred = succ(d);
                if (m_hits == 4) begin
                    m_locked = 1; m_hits = 0; m_miss = 0;
                end
            end
        end
        push_exp(err, pvld);
    endtask

    // Clean stream; pct is the percentage of cycles carrying a valid sample.
    task automatic clean(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < pct) begin
                drive(1'b1, g);
                g = succ(g);
            end else begin
                drive(1'b0, 10'($urandom));
            end
        end
    endtask

    task automatic corrupt(input logic [9:0] mask);
        drive(1'b1, g ^ mask);
        g = succ(g);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked_o", locked_o, e.locked);
                chk("err_o", err_o, e.err);
                chk("err_cnt_o", err_cnt_o, e.cnt);
                chk("period_vld_o", period_vld_o, e.pvld);
                chk("period_o", period_o, e.period);
            end
        end
    end

    initial begin : stim
        logic [9:0] w;
        w = 10'd1;
        for (int i = 0; i < 1023; i++) begin
            seq[i] = w;
            pos[w] = i;
            w = {w[8:0], w[9] ^ w[6]};
        end
        pos[0] = 0;
        model_reset();
        g = seq[$urandom_range(0, 1022)];

        do_reset(2);
        clean(10, 100);
        corrupt(10'h008);
        clean(5, 100);
        for (int i = 0; i < 3; i++) corrupt(10'($urandom_range(1, 1023)));
        clean(12, 100);
        corrupt(10'h008);
        clean(2800, 80);

        do_reset(1);
        clean(20, 100);

        do_reset(2);
        for (int i = 0; i < 30; i++) drive(1'b1, 10'd0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 10) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b1, 10'd0);
                    g = succ(g);
                end else begin
                    corrupt(10'($urandom_range(1, 1023)));
                end
            end else begin
                clean(1, 85);
            end
        end

        @(negedge clk);
        en_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
